track_recorder: RTL and testbench

// - Write-side counterpart of the track playback path: captures player key presses on the game tick and packs them into 4-slot words.
// - Writes those words into the four track RAMs through their data/wren/address ports, so recorded patterns replay through the existing load/shift chain.
// - Sits beside the playback path. It shares the game-tick divider output and drives the address mux when recording is active.

---
 rtl/track_recorder_pkg.sv | 15 +
 rtl/track_recorder_if.sv | 25 ++
 rtl/track_recorder_key_sync.sv | 22 ++
 rtl/track_recorder.sv | 131 +++++++++++++
 tb/tb_track_recorder.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/track_recorder_pkg.sv
// Shared types and default sizes for the track recorder.
// Included first by every recorder source.
package track_recorder_pkg;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_SLOTS  = 4;
  localparam int DEF_TRACKS = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CAPTURE,
    FLUSH,
    DONE
  } state_t;
endpackage

// File: rtl/track_recorder_if.sv
// Write bus from the recorder into the four track RAMs.
// Master drives address, packed word and the write strobe.
interface track_recorder_if
  import track_recorder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SLOTS  = DEF_SLOTS,
  parameter int TRACKS = DEF_TRACKS
);
  logic [ADDR_W-1:0]       wr_addr;
  logic [TRACKS*SLOTS-1:0] wr_data;
  logic                    wren;

  modport master (
    output wr_addr,
    output wr_data,
    output wren
  );

  modport slave (
    input wr_addr,
    input wr_data,
    input wren
  );
endinterface

// File: rtl/track_recorder_key_sync.sv
// Two-flop synchronizer for the raw active-low keys.
// Resets to all ones so every key reads as released.
module key_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/track_recorder.sv
// Captures key presses on the game tick, packs them into 4-slot
// words and writes them into the track RAMs.
module track_recorder
  import track_recorder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SLOTS  = DEF_SLOTS,
  parameter int TRACKS = DEF_TRACKS
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              record_en,
  input  logic [TRACKS-1:0] key_n,
  track_recorder_if.master  wr,
  output logic              recording,
  output logic              done,
  output logic [ADDR_W:0]   words_written
);
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int DW = TRACKS * SLOTS;
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  state_t            state, nxt;
  logic [TRACKS-1:0] key_q;
  logic [TRACKS-1:0] note;
  logic [SW-1:0]     slot;
  logic [DW-1:0]     cap, cap_nx, data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wren_q;
  logic              last_addr;
  logic              sample;
  logic              start;

  key_sync #(.W(TRACKS)) u_sync (
    .clk    (CLOCK_50),
    .reset_n(reset_n),
    .d      (key_n),
    .q      (key_q)
  );

  assign note      = ~key_q;
  assign last_addr = &addr_q;
  assign start     = (state == IDLE) && record_en;
  // A tick landing on the final write of a full RAM belongs to DONE.
  assign sample    = tick &&
                     (((state == ARM) && record_en) ||
                      ((state == CAPTURE) && !(wren_q && last_addr)));

  assign wr.wr_addr = addr_q;
  assign wr.wr_data = data_q;
  assign wr.wren    = wren_q;
  assign recording  = (state == ARM) || (state == CAPTURE) ||
                      (state == FLUSH);
  assign done       = (state == DONE);

  // Nibble t holds track t+1, driven by KEY[TRACKS-1-t].
  always_comb begin
    cap_nx = cap;
    for (int t = 0; t < TRACKS; t++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (slot == SW'(s)) begin
          cap_nx[t*SLOTS+s] = note[TRACKS-1-t];
        end
      end
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (record_en) nxt = ARM;
      ARM: begin
        if (!record_en)  nxt = IDLE;
        else if (tick)   nxt = CAPTURE;
      end
      CAPTURE: begin
        if (wren_q && last_addr) nxt = DONE;
        else if (!record_en)     nxt = FLUSH;
      end
      FLUSH:   nxt = IDLE;
      DONE:    if (!record_en) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      addr_q        <= '0;
      data_q        <= '0;
      wren_q        <= 1'b0;
      words_written <= '0;
      slot          <= '0;
      cap           <= '0;
    end else begin
      wren_q <= 1'b0;
      if (wren_q) begin
        words_written <= words_written + (ADDR_W+1)'(1);
        if (!last_addr) addr_q <= addr_q + ADDR_W'(1);
      end
      if (start) begin
        addr_q        <= '0;
        words_written <= '0;
        slot          <= '0;
        cap           <= '0;
      end
      if (sample) begin
        if (slot == LAST_SLOT) begin
          data_q <= cap_nx;
          cap    <= '0;
          slot   <= '0;
          wren_q <= 1'b1;
        end else begin
          cap  <= cap_nx;
          slot <= slot + SW'(1);
        end
      end
      if ((state == FLUSH) && (slot != '0)) begin
        data_q <= cap;
        cap    <= '0;
        slot   <= '0;
        wren_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_track_recorder.sv
// Randomized bench for track_recorder with a slot/word
// reference model of the recorded take.
module tb_track_recorder;
  import track_recorder_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       record_en = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic       recording, done;
  logic [7:0] words_written;

  int checks = 0;
  int passed = 0;

  track_recorder_if wr_bus ();

  track_recorder dut (
    .CLOCK_50     (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .record_en    (record_en),
    .key_n        (key_n),
    .wr           (wr_bus),
    .recording    (recording),
    .done         (done),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  logic [6:0]  obs_addr[$];
  logic [15:0] obs_data[$];
  logic [6:0]  exp_addr[$];
  logic [15:0] exp_data[$];
  logic        prev_wren = 1'b0;
  int          dbl_wren = 0;

  always @(negedge clk) begin
    if (wr_bus.wren) begin
      obs_addr.push_back(wr_bus.wr_addr);
      obs_data.push_back(wr_bus.wr_data);
      if (prev_wren) dbl_wren++;
    end
    prev_wren = wr_bus.wren;
  end

  // Reference model: notes fill slots in tick order, four per word.
  int          m_slot;
  int          m_addr;
  logic [15:0] m_word;

  function automatic void model_start();
    m_slot = 0;
    m_addr = 0;
    m_word = '0;
    exp_addr.delete();
    exp_data.delete();
  endfunction

  function automatic void model_tick(input logic [3:0] p);
    if (m_addr >= 128) return;
    for (int t = 0; t < 4; t++) m_word[t*4+m_slot] = p[3-t];
    m_slot++;
    if (m_slot == 4) begin
      exp_addr.push_back(7'(m_addr));
      exp_data.push_back(m_word);
      m_addr++;
      m_slot = 0;
      m_word = '0;
    end
  endfunction

  function automatic void model_flush();
    if (m_slot > 0 && m_addr < 128) begin
      exp_addr.push_back(7'(m_addr));
      exp_data.push_back(m_word);
      m_addr++;
      m_slot = 0;
      m_word = '0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    dbl_wren = 0;
  endtask

  task automatic start_take();
    record_en = 1'b0;
    step();
    record_en = 1'b1;
    step();
    model_start();
    clear_obs();
  endtask

  task automatic do_tick(input logic [3:0] p, input bit fall);
    key_n = ~p;
    repeat (3) step();
    tick = 1'b1;
    if (fall) record_en = 1'b0;
    step();
    tick = 1'b0;
    model_tick(p);
  endtask

  task automatic compare_writes(input string tag);
    checks++;
    if (obs_addr.size() !== exp_addr.size()) begin
      $display("FAIL %s write count: got %0d expected %0d",
               tag, obs_addr.size(), exp_addr.size());
    end else begin
      passed++;
      foreach (exp_addr[i]) begin
        checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
          $display("FAIL %s write %0d: got %0d/%h expected %0d/%h",
                   tag, i, obs_addr[i], obs_data[i],
                   exp_addr[i], exp_data[i]);
        else passed++;
      end
    end
    checks++;
    if (dbl_wren !== 0)
      $display("FAIL %s wren streak: got %0d expected 0", tag, dbl_wren);
    else passed++;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    record_en = 1'b1;
    clear_obs();
    repeat (3) step();
    checks++;
    if ({wr_bus.wren, wr_bus.wr_addr, wr_bus.wr_data, recording,
         done, words_written} !== '0)
      $display("FAIL reset outputs: got %b/%0d/%h/%b/%b/%0d expected 0",
               wr_bus.wren, wr_bus.wr_addr, wr_bus.wr_data,
               recording, done, words_written);
    else passed++;
    checks++;
    if (obs_addr.size() !== 0)
      $display("FAIL reset wren: got %0d writes expected 0",
               obs_addr.size());
    else passed++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_full_word();
    start_take();
    checks++;
    if (recording !== 1'b1)
      $display("FAIL arm recording: got %b expected 1", recording);
    else passed++;
    do_tick(4'b1000, 0);
    do_tick(4'b0000, 0);
    do_tick(4'b1000, 0);
    do_tick(4'b0000, 0);
    repeat (3) step();
    checks++;
    if (obs_data.size() != 1 || obs_data[0] !== 16'h0005 ||
        obs_addr[0] !== 7'd0)
      $display("FAIL full word: got %0d writes first %h expected 1 of 0005",
               obs_data.size(), obs_data.size() ? obs_data[0] : 16'h0);
    else passed++;
    compare_writes("full_word");
    checks++;
    if (words_written !== 8'd1)
      $display("FAIL full word count: got %0d expected 1", words_written);
    else passed++;
    record_en = 1'b0;
    repeat (3) step();
    checks++;
    if (recording !== 1'b0 || obs_addr.size() != 1)
      $display("FAIL empty flush: got rec %b writes %0d expected 0/1",
               recording, obs_addr.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    start_take();
    key_n = 4'h0;
    repeat (3) step();
    tick = 1'b1;
    repeat (8) begin
      step();
      model_tick(4'hF);
    end
    tick = 1'b0;
    repeat (4) step();
    compare_writes("back_to_back");
    checks++;
    if (obs_data.size() != 2 || obs_addr[1] !== 7'd1 ||
        obs_data[1] !== 16'hFFFF)
      $display("FAIL b2b second word: got %0d writes expected 2",
               obs_data.size());
    else passed++;
    checks++;
    if (words_written !== 8'd2)
      $display("FAIL b2b count: got %0d expected 2", words_written);
    else passed++;
    record_en = 1'b0;
    key_n = 4'hF;
    repeat (3) step();
  endtask

  task automatic test_partial_flush();
    start_take();
    do_tick(4'b0001, 0);
    do_tick(4'b0001, 0);
    record_en = 1'b0;
    model_flush();
    repeat (4) step();
    compare_writes("partial");
    checks++;
    if (obs_data.size() != 1 || obs_data[0] !== 16'h3000)
      $display("FAIL partial data: got %0d writes expected 1 of 3000",
               obs_data.size());
    else passed++;
    checks++;
    if (recording !== 1'b0 || done !== 1'b0)
      $display("FAIL partial idle: got rec %b done %b expected 0/0",
               recording, done);
    else passed++;
  endtask

  task automatic test_random_take();
    int n;
    start_take();
    n = $urandom_range(20, 40);
    for (int i = 0; i < n; i++) begin
      do_tick(4'($urandom), 0);
      repeat ($urandom_range(0, 2)) step();
    end
    do_tick(4'($urandom), 1);
    model_flush();
    repeat (4) step();
    compare_writes("random");
    checks++;
    if (words_written !== 8'(exp_addr.size()))
      $display("FAIL random count: got %0d expected %0d",
               words_written, exp_addr.size());
    else passed++;
  endtask

  task automatic test_full_ram();
    start_take();
    for (int i = 0; i < 512; i++) do_tick(4'($urandom), 0);
    repeat (3) step();
    compare_writes("full_ram");
    checks++;
    if (done !== 1'b1 || words_written !== 8'd128 || recording !== 1'b0)
      $display("FAIL full ram: got done %b count %0d expected 1/128",
               done, words_written);
    else passed++;
    clear_obs();
    for (int i = 0; i < 8; i++) do_tick(4'hF, 0);
    repeat (2) step();
    checks++;
    if (obs_addr.size() !== 0)
      $display("FAIL done ticks: got %0d writes expected 0",
               obs_addr.size());
    else passed++;
    record_en = 1'b0;
    repeat (2) step();
    checks++;
    if (done !== 1'b0 || recording !== 1'b0)
      $display("FAIL done exit: got done %b expected 0", done);
    else passed++;
  endtask

  task automatic test_mid_reset();
    start_take();
    for (int i = 0; i < 22; i++) do_tick(4'($urandom), 0);
    repeat (2) step();
    compare_writes("pre_reset");
    clear_obs();
    reset_n = 1'b0;
    step();
    checks++;
    if (wr_bus.wr_addr !== 7'd0 || words_written !== 8'd0 ||
        recording !== 1'b0 || wr_bus.wren !== 1'b0)
      $display("FAIL mid reset: got addr %0d count %0d rec %b",
               wr_bus.wr_addr, words_written, recording);
    else passed++;
    record_en = 1'b0;
    reset_n = 1'b1;
    repeat (6) step();
    checks++;
    if (obs_addr.size() !== 0)
      $display("FAIL mid reset write: got %0d expected 0",
               obs_addr.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_partial_flush();
    test_random_take();
    test_full_ram();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
